// File: rtl/safe_divisor_pkg.sv
// Shared types and lane-clamp helpers for safe_divisor_stage.
// Lanes are handled at a fixed maximum width and masked to the real lane width.
package safe_divisor_pkg;

    localparam int unsigned MaxW = 64;

    typedef logic [MaxW-1:0] lane_t;

    typedef struct packed {
        lane_t value;
        logic  replaced;
    } clamp_t;

    function automatic lane_t width_mask(input int unsigned width);
        lane_t m;
        m = '1;
        if (width < MaxW) begin
            m = ~(m << width);
        end
        return m;
    endfunction

    // Zero floor becomes 1; signed lanes cap at the largest positive value.
    function automatic lane_t eff_floor(input lane_t cfg, input int unsigned width,
                                        input logic signed_mode);
        lane_t f;
        lane_t cap;
        f   = (cfg == '0) ? lane_t'(1) : cfg;
        cap = width_mask(width) >> 1;
        if (signed_mode && (f > cap)) begin
            f = cap;
        end
        return f;
    endfunction

    function automatic clamp_t clamp_lane(input lane_t x, input lane_t flr,
                                          input int unsigned width, input logic signed_mode);
        lane_t  mask;
        lane_t  mag;
        logic   neg;
        clamp_t res;
        mask = width_mask(width);
        neg  = signed_mode && ((x & (lane_t'(1) << (width - 1))) != '0);
        // Most-negative value negates to itself, i.e. magnitude 2^(width-1).
        mag  = neg ? ((~x + lane_t'(1)) & mask) : (x & mask);
        res.replaced = (mag < flr);
        res.value    = x & mask;
        if (res.replaced) begin
            res.value = neg ? ((~flr + lane_t'(1)) & mask) : flr;
        end
        return res;
    endfunction

endpackage

// File: rtl/safe_divisor_stage_skid.sv
// Registered AXI-Stream stage with a one-entry skid register.
// Upstream ready is registered and simply reflects an empty skid slot.
module axis_skid_buffer #(
    parameter int unsigned       DATA_W  = 8,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_s_data,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    output logic [DATA_W-1:0] o_m_data,
    output logic              o_m_valid,
    input  logic              i_m_ready
);

    logic [DATA_W-1:0] r_main_data, w_main_data_next;
    logic              r_main_valid, w_main_valid_next;
    logic [DATA_W-1:0] r_skid_data, w_skid_data_next;
    logic              r_skid_valid, w_skid_valid_next;
    logic              r_s_ready;
    logic              w_accept;
    logic              w_load;

    assign w_accept = i_s_valid && r_s_ready;
    assign w_load   = !r_main_valid || i_m_ready;

    always_comb begin
        w_main_data_next  = r_main_data;
        w_main_valid_next = r_main_valid;
        w_skid_data_next  = r_skid_data;
        w_skid_valid_next = r_skid_valid;
        if (w_load) begin
            if (r_skid_valid) begin
                w_main_data_next  = r_skid_data;
                w_main_valid_next = 1'b1;
                w_skid_valid_next = 1'b0;
            end else if (w_accept) begin
                w_main_data_next  = i_s_data;
                w_main_valid_next = 1'b1;
            end else begin
                w_main_valid_next = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_data_next  = i_s_data;
            w_skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_main_data  <= RST_VAL;
            r_main_valid <= 1'b0;
            r_skid_data  <= RST_VAL;
            r_skid_valid <= 1'b0;
            r_s_ready    <= 1'b1;
        end else begin
            r_main_data  <= w_main_data_next;
            r_main_valid <= w_main_valid_next;
            r_skid_data  <= w_skid_data_next;
            r_skid_valid <= w_skid_valid_next;
            r_s_ready    <= !w_skid_valid_next;
        end
    end

    assign o_s_ready = r_s_ready;
    assign o_m_data  = r_main_data;
    assign o_m_valid = r_main_valid;

endmodule

// File: rtl/safe_divisor_stage.sv
// Forces every lane to at least a runtime magnitude floor before the metric divider.
// Clamps are combinational ahead of a registered skid stage; a saturating counter tracks clamps.
module safe_divisor_stage #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NCHAN     = 1,
    parameter int unsigned SIGNED    = 0,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       cfg_floor,
    input  logic [NCHAN*WIDTH-1:0] i_tdata,
    input  logic                   i_tlast,
    input  logic                   i_tvalid,
    output logic                   i_tready,
    output logic [NCHAN*WIDTH-1:0] o_tdata,
    output logic [NCHAN-1:0]       o_tuser,
    output logic                   o_tlast,
    output logic                   o_tvalid,
    input  logic                   o_tready,
    output logic [CNT_WIDTH-1:0]   clamp_count
);
    import safe_divisor_pkg::*;

    localparam int unsigned       DataW      = NCHAN * WIDTH + NCHAN + 1;
    localparam logic              SignedMode = (SIGNED != 0);
    localparam logic [DataW-1:0]  RstVal     = {1'b0, {NCHAN{1'b0}}, {(NCHAN * WIDTH){1'b1}}};

    lane_t                  w_floor;
    logic [NCHAN*WIDTH-1:0] w_tdata;
    logic [NCHAN-1:0]       w_tuser;
    logic                   w_accept;
    logic                   w_in_ready;
    logic [DataW-1:0]       w_out_data;
    logic [CNT_WIDTH-1:0]   r_clamp_count, w_clamp_count_next;

    assign w_floor = eff_floor(lane_t'(cfg_floor), WIDTH, SignedMode);

    for (genvar k = 0; k < NCHAN; k++) begin : g_lane
        clamp_t w_res;
        assign w_res = clamp_lane(lane_t'(i_tdata[k*WIDTH +: WIDTH]), w_floor, WIDTH, SignedMode);
        assign w_tdata[k*WIDTH +: WIDTH] = w_res.value[WIDTH-1:0];
        assign w_tuser[k]                = w_res.replaced;
        if (WIDTH < MaxW) begin : g_hi
            // Upper bits are always zero after masking.
            logic w_unused_hi;
            assign w_unused_hi = ^w_res.value[MaxW-1:WIDTH];
        end
    end

    assign w_accept = i_tvalid && w_in_ready;

    always_comb begin
        w_clamp_count_next = r_clamp_count;
        if (w_accept && (|w_tuser) && (r_clamp_count != '1)) begin
            w_clamp_count_next = r_clamp_count + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_clamp_count <= '0;
        end else begin
            r_clamp_count <= w_clamp_count_next;
        end
    end

    axis_skid_buffer #(
        .DATA_W  (DataW),
        .RST_VAL (RstVal)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (clear),
        .i_s_data  ({i_tlast, w_tuser, w_tdata}),
        .i_s_valid (i_tvalid),
        .o_s_ready (w_in_ready),
        .o_m_data  (w_out_data),
        .o_m_valid (o_tvalid),
        .i_m_ready (o_tready)
    );

    assign i_tready                     = w_in_ready;
    assign {o_tlast, o_tuser, o_tdata}  = w_out_data;
    assign clamp_count                  = r_clamp_count;

endmodule

// File: tb/tb_safe_divisor_stage.sv
// Bench for safe_divisor_stage: a signed 2-lane and an unsigned 1-lane instance share one
// handshake; a scoreboard checks outputs against an arithmetic reference model.
module tb_safe_divisor_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] cfg_floor = '0;
    logic [31:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        o_tready = 1'b0;

    logic        s_tready, s_tlast, s_tvalid;
    logic [31:0] s_tdata;
    logic [1:0]  s_tuser;
    logic [15:0] s_count;
    logic        u_tready, u_tlast, u_tvalid;
    logic [15:0] u_tdata;
    logic [0:0]  u_tuser;
    logic [2:0]  u_count;

    safe_divisor_stage #(.WIDTH(16), .NCHAN(2), .SIGNED(1), .CNT_WIDTH(16)) u_dut_s (
        .clk(clk), .reset(reset), .clear(clear), .cfg_floor(cfg_floor),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(s_tready),
        .o_tdata(s_tdata), .o_tuser(s_tuser), .o_tlast(s_tlast), .o_tvalid(s_tvalid),
        .o_tready(o_tready), .clamp_count(s_count)
    );

    safe_divisor_stage #(.WIDTH(16), .NCHAN(1), .SIGNED(0), .CNT_WIDTH(3)) u_dut_u (
        .clk(clk), .reset(reset), .clear(clear), .cfg_floor(cfg_floor),
        .i_tdata(i_tdata[15:0]), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(u_tready),
        .o_tdata(u_tdata), .o_tuser(u_tuser), .o_tlast(u_tlast), .o_tvalid(u_tvalid),
        .o_tready(o_tready), .clamp_count(u_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d_s;
        logic [1:0]  u_s;
        logic [15:0] d_u;
        logic        u_u;
        logic        last;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cnt_s = 0;
    int unsigned cnt_u = 0;
    int          accepted = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int unsigned ref_floor(input logic [15:0] cfg, input bit sgn);
        int unsigned f;
        f = (cfg == 0) ? 1 : int'(cfg);
        if (sgn && f > 32767) f = 32767;
        return f;
    endfunction

    function automatic void ref_unsigned(input logic [15:0] x, input int unsigned f,
                                         output logic [15:0] y, output logic r);
        r = (int'(x) < int'(f));
        y = r ? 16'(f) : x;
    endfunction

    function automatic void ref_signed(input logic [15:0] x, input int unsigned f,
                                       output logic [15:0] y, output logic r);
        int xs;
        int mag;
        xs  = int'($signed(x));
        mag = (xs < 0) ? -xs : xs;
        r   = (mag < int'(f));
        y   = r ? 16'((xs < 0) ? -int'(f) : int'(f)) : x;
    endfunction

    function automatic exp_t model(input logic [31:0] d, input logic last, input logic [15:0] cfg);
        exp_t        e;
        logic [15:0] y;
        logic        r;
        for (int k = 0; k < 2; k++) begin
            ref_signed(d[k*16 +: 16], ref_floor(cfg, 1'b1), y, r);
            e.d_s[k*16 +: 16] = y;
            e.u_s[k]          = r;
        end
        ref_unsigned(d[15:0], ref_floor(cfg, 1'b0), y, r);
        e.d_u  = y;
        e.u_u  = r;
        e.last = last;
        return e;
    endfunction

    // One cycle: check state left by the last edge, then drive inputs for the next edge.
    task automatic step(input logic v, input logic [31:0] d, input logic last, input logic rdy,
                        input logic [15:0] cfg, input logic clr);
        exp_t e;
        @(negedge clk);
        chk("i_tready_s", s_tready, q.size() < 2);
        chk("i_tready_u", u_tready, q.size() < 2);
        chk("o_tvalid_s", s_tvalid, q.size() > 0);
        chk("o_tvalid_u", u_tvalid, q.size() > 0);
        chk("count_s", s_count, cnt_s);
        chk("count_u", u_count, cnt_u);
        i_tvalid  = v;
        i_tdata   = d;
        i_tlast   = last;
        o_tready  = rdy;
        cfg_floor = cfg;
        clear     = clr;
        if (clr) begin
            q.delete();
            cnt_s = 0;
            cnt_u = 0;
        end else if (v && s_tready) begin
            e = model(d, last, cfg);
            q.push_back(e);
            accepted++;
            if ((|e.u_s) && cnt_s != 65535) cnt_s++;
            if (e.u_u && cnt_u != 7) cnt_u++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
    endtask

    function automatic logic [15:0] rand_lane();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom_range(0, 12));
            1:       return 16'(-int'($urandom_range(0, 12)));
            2:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [15:0] rand_cfg();
        case ($urandom_range(0, 3))
            0:       return 16'd0;
            1:       return 16'($urandom_range(1, 10));
            2:       return 16'($urandom);
            default: return 16'hFFFF;
        endcase
    endfunction

    // Monitor: compares every presented beat with the queue head, pops on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && !clear && s_tvalid) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = q[0];
                    chk("tdata_s", s_tdata, e.d_s);
                    chk("tuser_s", s_tuser, e.u_s);
                    chk("tlast_s", s_tlast, e.last);
                    chk("tdata_u", u_tdata, e.d_u);
                    chk("tuser_u", u_tuser, e.u_u);
                    chk("tlast_u", u_tlast, e.last);
                    if (o_tready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        int a0;
        int cyc;

        repeat (2) @(negedge clk);
        chk("rst_tvalid", s_tvalid, 0);
        chk("rst_tready", s_tready, 1);
        chk("rst_tdata_s", s_tdata, 32'hFFFF_FFFF);
        chk("rst_tdata_u", u_tdata, 16'hFFFF);
        chk("rst_tuser", s_tuser, 0);
        chk("rst_tlast", s_tlast, 0);
        chk("rst_count", s_count, 0);
        reset = 1'b0;

        // Unsigned floor 0 -> 1: lane0 inputs 0, 1, 5.
        step(1'b1, {16'd100, 16'd0}, 1'b0, 1'b1, 16'd0, 1'b0);
        step(1'b1, {16'd200, 16'd1}, 1'b0, 1'b1, 16'd0, 1'b0);
        step(1'b1, {16'd300, 16'd5}, 1'b1, 1'b1, 16'd0, 1'b0);
        idle(3);
        chk("t1_count_u", u_count, 1);

        // Signed floor 4: lanes (lane0, lane1) = (-3,2), (0,-32768), (7,-4).
        step(1'b1, {16'd2, 16'hFFFD}, 1'b0, 1'b1, 16'd4, 1'b0);
        step(1'b1, {16'h8000, 16'h0000}, 1'b0, 1'b1, 16'd4, 1'b0);
        step(1'b1, {16'hFFFC, 16'd7}, 1'b1, 1'b1, 16'd4, 1'b0);
        idle(3);
        chk("t2_count_s", s_count, 3);

        // Downstream stall for 5 cycles under continuous input.
        a0 = accepted;
        for (int i = 0; i < 5; i++) step(1'b1, {rand_lane(), rand_lane()}, 1'b0, 1'b0, 16'd3, 1'b0);
        chk("stall_accepted", accepted - a0, 2);
        for (int i = 0; i < 6; i++) step(1'b1, {rand_lane(), rand_lane()}, i == 5, 1'b1, 16'd3, 1'b0);
        idle(3);

        // Clear mid-packet with main and skid both full.
        for (int i = 0; i < 3; i++) step(1'b1, '0, 1'b0, 1'b0, 16'd2, 1'b0);
        step(1'b1, '0, 1'b0, 1'b0, 16'd2, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 16'd2, 1'b0);
        chk("clr_tvalid", s_tvalid, 0);
        chk("clr_tready", s_tready, 1);
        chk("clr_count", s_count, 0);
        chk("clr_tdata", s_tdata, 32'hFFFF_FFFF);
        for (int i = 0; i < 8; i++) step(1'b1, {rand_lane(), rand_lane()}, i == 7, 1'b1, 16'd5, 1'b0);
        idle(3);

        // Counter saturation in the 3-bit instance.
        step(1'b0, '0, 1'b0, 1'b1, '0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, '0, 1'b0, 1'b1, 16'd0, 1'b0);
        idle(3);
        chk("sat_count_u", u_count, 7);
        chk("sat_count_s", s_count, 10);

        // Random traffic with random backpressure.
        a0  = accepted;
        cyc = 0;
        while ((accepted - a0) < 1000 && cyc < 20000) begin
            step(1'($urandom_range(0, 1)), {rand_lane(), rand_lane()},
                 ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), rand_cfg(), 1'b0);
            cyc++;
        end
        chk("random_budget", (accepted - a0) >= 1000, 1);

        cyc = 0;
        while (q.size() != 0 && cyc < 50) begin
            idle(1);
            cyc++;
        end
        idle(1);
        chk("drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
